// File: rtl/eq_tap_update_sequencer.sv
// Coefficient-adaptation sequencer: one error sample triggers a read-modify-write
// sweep over all equalizer taps through a two-stage multiply / shift-subtract pipeline.
module eq_tap_update_sequencer #(
  parameter int NTAPS             = 16,
  parameter int COEF_W            = 16,
  parameter int X_W               = 16,
  parameter int ERR_W             = 16,
  parameter int MU_SHIFT_CMA      = 10,
  parameter int MU_SHIFT_LMS_FAST = 8,
  parameter int MU_SHIFT_LMS_SLOW = 12,
  parameter int GEAR_ITERS        = 4096,
  localparam int AW               = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [2:0]        adaptation_phase,
  input  logic [31:0]       iteration_count,
  input  logic              err_valid,
  input  logic [ERR_W-1:0]  err_data,
  output logic              err_ready,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [COEF_W-1:0] coef_rd_data,
  input  logic [X_W-1:0]    x_rd_data,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [COEF_W-1:0] wr_data,
  output logic              busy,
  output logic              sweep_done,
  output logic              sat_flag,
  output logic [31:0]       sweep_count
);

  localparam int PW = ERR_W + X_W;
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
  localparam logic [31:0]   GEAR_L   = 32'(GEAR_ITERS);
  localparam logic [7:0]    SH_CMA   = 8'(MU_SHIFT_CMA);
  localparam logic [7:0]    SH_FAST  = 8'(MU_SHIFT_LMS_FAST);
  localparam logic [7:0]    SH_SLOW  = 8'(MU_SHIFT_LMS_SLOW);
  localparam logic signed [PW:0] SAT_HI = {{(PW + 2 - COEF_W){1'b0}}, {(COEF_W - 1){1'b1}}};
  localparam logic signed [PW:0] SAT_LO = {{(PW + 2 - COEF_W){1'b1}}, {(COEF_W - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        tap_q, tap_d;
  logic                 drain_q, drain_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [7:0]           shift_q, shift_d;
  logic                 rd_v_q, rd_v_d;
  logic [AW-1:0]        rd_tag_q, rd_tag_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic [COEF_W-1:0]    coef_q, coef_d;
  logic                 wr_v_q, wr_v_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic                 sat_flag_q, sat_flag_d;
  logic                 sweep_done_q, sweep_done_d;
  logic [31:0]          sweep_count_q, sweep_count_d;

  logic                 accept;
  logic                 phase_active;
  logic [PW-1:0]        err_ext, x_ext;
  logic signed [PW-1:0] delta;
  logic signed [PW:0]   new_full;
  logic                 clamp_hi, clamp_lo;

  assign err_ready    = !rst && (state_q == S_IDLE) && enable;
  assign accept       = err_valid && err_ready;
  assign phase_active = (adaptation_phase == 3'd1) || (adaptation_phase == 3'd2);

  assign rd_en       = (state_q == S_SWEEP);
  assign rd_addr     = tap_q;
  assign wr_en       = wr_v_q;
  assign wr_addr     = wr_addr_q;
  assign busy        = (state_q != S_IDLE);
  assign sweep_done  = sweep_done_q;
  assign sat_flag    = sat_flag_q;
  assign sweep_count = sweep_count_q;

  // Stage 2: floor step via arithmetic shift, subtract in one extra bit, then clamp.
  always_comb begin
    err_ext  = {{X_W{err_q[ERR_W-1]}}, err_q};
    x_ext    = {{ERR_W{x_rd_data[X_W-1]}}, x_rd_data};
    delta    = prod_q >>> shift_q;
    new_full = {{(PW + 1 - COEF_W){coef_q[COEF_W-1]}}, coef_q} - {delta[PW-1], delta};
    clamp_hi = (new_full > SAT_HI);
    clamp_lo = (new_full < SAT_LO);
    if (clamp_hi) begin
      wr_data = {1'b0, {(COEF_W - 1){1'b1}}};
    end else if (clamp_lo) begin
      wr_data = {1'b1, {(COEF_W - 1){1'b0}}};
    end else begin
      wr_data = new_full[COEF_W-1:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    tap_d         = tap_q;
    drain_d       = drain_q;
    err_d         = err_q;
    shift_d       = shift_q;
    sweep_done_d  = 1'b0;
    sweep_count_d = sweep_count_q;

    case (state_q)
      S_IDLE: begin
        // Samples offered outside CMA/LMS are consumed but start nothing.
        if (accept && phase_active) begin
          state_d = S_SWEEP;
          tap_d   = '0;
          err_d   = err_data;
          if (adaptation_phase == 3'd1) begin
            shift_d = SH_CMA;
          end else if (iteration_count < GEAR_L) begin
            shift_d = SH_FAST;
          end else begin
            shift_d = SH_SLOW;
          end
        end
      end
      S_SWEEP: begin
        if (tap_q == LAST_TAP) begin
          state_d = S_DRAIN;
          tap_d   = '0;
          drain_d = 1'b0;
        end else begin
          tap_d = tap_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d       = S_IDLE;
          sweep_done_d  = 1'b1;
          sweep_count_d = sweep_count_q + 32'd1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stage 1 captures RAM data the cycle after the read strobe.
    rd_v_d    = (state_q == S_SWEEP);
    rd_tag_d  = tap_q;
    prod_d    = prod_q;
    coef_d    = coef_q;
    if (rd_v_q) begin
      prod_d = prod_q;
      prod_d = err_ext * x_ext;
      coef_d = coef_rd_data;
    end
    wr_v_d     = rd_v_q;
    wr_addr_d  = rd_tag_q;
    sat_flag_d = sat_flag_q | (wr_v_q & (clamp_hi | clamp_lo));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tap_q         <= '0;
      drain_q       <= 1'b0;
      err_q         <= '0;
      shift_q       <= '0;
      rd_v_q        <= 1'b0;
      rd_tag_q      <= '0;
      prod_q        <= '0;
      coef_q        <= '0;
      wr_v_q        <= 1'b0;
      wr_addr_q     <= '0;
      sat_flag_q    <= 1'b0;
      sweep_done_q  <= 1'b0;
      sweep_count_q <= '0;
    end else begin
      state_q       <= state_d;
      tap_q         <= tap_d;
      drain_q       <= drain_d;
      err_q         <= err_d;
      shift_q       <= shift_d;
      rd_v_q        <= rd_v_d;
      rd_tag_q      <= rd_tag_d;
      prod_q        <= prod_d;
      coef_q        <= coef_d;
      wr_v_q        <= wr_v_d;
      wr_addr_q     <= wr_addr_d;
      sat_flag_q    <= sat_flag_d;
      sweep_done_q  <= sweep_done_d;
      sweep_count_q <= sweep_count_d;
    end
  end

endmodule
